// File: rtl/icache_line_fetcher.sv
// Line-fill responder for the instruction cache: streams one line out of a byte-wide RAM,
// packs it little-endian into a single wide word and returns it with a one-cycle done pulse.
module icache_line_fetcher #(
  parameter int LINE_BYTES = 16,
  parameter int ADDR_W     = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    mem_rd_ena,
  input  logic [ADDR_W-1:0]       mem_rd_addr,
  output logic                    mem_rd_done,
  output logic [8*LINE_BYTES-1:0] mem_rd_data,
  output logic                    busy,
  output logic                    ram_rd,
  output logic [ADDR_W-1:0]       ram_a,
  input  logic [7:0]              ram_din,
  output logic                    ram_wr
);

  localparam int                OFF_W    = $clog2(LINE_BYTES);
  localparam int                LINE_W   = 8 * LINE_BYTES;
  localparam logic [OFF_W-1:0]  LAST_IDX = OFF_W'(LINE_BYTES - 1);
  localparam logic [OFF_W-1:0]  ONE_IDX  = OFF_W'(1);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [OFF_W-1:0]   issIdx_q, issIdx_d;
  logic [OFF_W-1:0]   rcvIdx_q, rcvIdx_d;
  logic               rdPend_q, rdPend_d;
  logic               ramRd_q, ramRd_d;
  logic [ADDR_W-1:0]  ramA_q, ramA_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [LINE_W-1:0]  data_q, data_d;

  logic               accept;
  logic               lastByte;
  logic [OFF_W-1:0]   issNext;
  logic [ADDR_W-1:0]  reqBase;

  assign accept   = mem_rd_ena && !clr;
  assign lastByte = rdPend_q && (rcvIdx_q == LAST_IDX);
  assign issNext  = issIdx_q + ONE_IDX;
  assign reqBase  = mem_rd_addr & ~OFF_MASK;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      base_q   <= '0;
      issIdx_q <= '0;
      rcvIdx_q <= '0;
      rdPend_q <= 1'b0;
      ramRd_q  <= 1'b0;
      ramA_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      issIdx_q <= issIdx_d;
      rcvIdx_q <= rcvIdx_d;
      rdPend_q <= rdPend_d;
      ramRd_q  <= ramRd_d;
      ramA_q   <= ramA_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      data_q   <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = FETCH;
      end
      FETCH: begin
        if (clr)           state_d = IDLE;
        else if (lastByte) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Issue and receive run one cycle apart; rdPend marks that the byte for the previous strobe is on ram_din.
  always_comb begin
    base_d   = base_q;
    issIdx_d = issIdx_q;
    rcvIdx_d = rcvIdx_q;
    rdPend_d = 1'b0;
    ramRd_d  = ramRd_q;
    ramA_d   = ramA_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    data_d   = data_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          base_d   = reqBase;
          issIdx_d = '0;
          rcvIdx_d = '0;
          ramRd_d  = 1'b1;
          ramA_d   = reqBase;
          busy_d   = 1'b1;
        end
      end
      FETCH: begin
        if (clr) begin
          issIdx_d = '0;
          rcvIdx_d = '0;
          ramRd_d  = 1'b0;
          ramA_d   = '0;
          busy_d   = 1'b0;
        end else begin
          rdPend_d = ramRd_q;
          if (ramRd_q) begin
            if (issIdx_q == LAST_IDX) begin
              ramRd_d = 1'b0;
            end else begin
              issIdx_d = issNext;
              ramA_d   = base_q | ADDR_W'(issNext);
            end
          end
          if (rdPend_q) begin
            data_d[{rcvIdx_q, 3'b000} +: 8] = ram_din;
            rcvIdx_d = rcvIdx_q + ONE_IDX;
            if (rcvIdx_q == LAST_IDX) done_d = 1'b1;
          end
        end
      end
      DONE: begin
        issIdx_d = '0;
        rcvIdx_d = '0;
        busy_d   = 1'b0;
      end
      default: begin
        busy_d  = 1'b0;
        ramRd_d = 1'b0;
      end
    endcase
  end

  assign mem_rd_done = done_q;
  assign mem_rd_data = data_q;
  assign busy        = busy_q;
  assign ram_rd      = ramRd_q;
  assign ram_a       = ramA_q;
  assign ram_wr      = 1'b0;

endmodule

// File: tb/tb_icache_line_fetcher.sv
// Self-checking bench for icache_line_fetcher: a cycle-position model of a fill
// checked every cycle, plus directed scenarios pinned with literal values.
module tb_icache_line_fetcher;

  logic         clk = 1'b0;
  logic         rst;
  logic         clr;
  logic         mem_rd_ena;
  logic [31:0]  mem_rd_addr;
  logic         mem_rd_done;
  logic [127:0] mem_rd_data;
  logic         busy;
  logic         ram_rd;
  logic [31:0]  ram_a;
  logic [7:0]   ram_din = 8'h00;
  logic         ram_wr;

  int nVectors    = 0;
  int nMiscompares = 0;
  bit checkEn     = 1'b0;
  logic [7:0] salt = 8'h00;

  // Model: mPos is the current cycle number of the fill (cycle 0 = request sampled)
  bit           mActive = 1'b0;
  int           mPos    = 0;
  logic [31:0]  mBase   = '0;
  logic [127:0] mData   = '0;
  bit           mZeroA  = 1'b1;

  icache_line_fetcher dut (
    .clk         (clk),
    .rst         (rst),
    .clr         (clr),
    .mem_rd_ena  (mem_rd_ena),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_done (mem_rd_done),
    .mem_rd_data (mem_rd_data),
    .busy        (busy),
    .ram_rd      (ram_rd),
    .ram_a       (ram_a),
    .ram_din     (ram_din),
    .ram_wr      (ram_wr)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ramByte(input logic [31:0] a, input logic [7:0] s);
    return (s == 8'h00) ? a[7:0] : (a[7:0] ^ a[23:16] ^ s);
  endfunction

  // RAM with one-cycle read latency; junk when not strobed so stray captures show up
  always @(posedge clk) begin
    if (ram_rd) ram_din <= ramByte(ram_a, salt);
    else        ram_din <= 8'($urandom);
  end

  always @(posedge clk) begin
    if (rst) begin
      mActive = 1'b0;
      mData   = '0;
      mZeroA  = 1'b1;
    end else if (!mActive) begin
      if (mem_rd_ena && !clr) begin
        mActive = 1'b1;
        mPos    = 1;
        mBase   = {mem_rd_addr[31:4], 4'h0};
        mZeroA  = 1'b0;
      end
    end else if (mPos == 18) begin
      mActive = 1'b0;
    end else if (clr) begin
      mActive = 1'b0;
      mZeroA  = 1'b1;
    end else begin
      if (mPos >= 2 && mPos <= 17)
        mData[8*(mPos-2) +: 8] = ramByte(mBase + 32'(mPos - 2), salt);
      mPos = mPos + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic c, input logic e, input logic [31:0] a);
    rst         = r;
    clr         = c;
    mem_rd_ena  = e;
    mem_rd_addr = a;
  endtask

  // Request is sampled at the next rising edge (cycle 0); returns just after it
  task automatic startFill(input logic [31:0] a);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b1, a);
    @(posedge clk);
    #1 applyStimulus(1'b0, 1'b0, 1'b0, a);
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("busy", 128'(busy), 128'(mActive));
      checkOutput("ram_rd", 128'(ram_rd), 128'(mActive && mPos <= 16));
      checkOutput("mem_rd_done", 128'(mem_rd_done), 128'(mActive && mPos == 18));
      checkOutput("mem_rd_data", mem_rd_data, mData);
      checkOutput("ram_wr", 128'(ram_wr), 128'(0));
      if (mActive && mPos <= 16)
        checkOutput("ram_a", 128'(ram_a), 128'(mBase + 32'(mPos - 1)));
      else if (mZeroA)
        checkOutput("ram_a_zero", 128'(ram_a), 128'(0));
    end
  end

  initial begin
    int doneCnt;
    int doneAt[2];

    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (3) @(posedge clk);
    #1 applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkEn = 1'b1;
    @(negedge clk);
    checkOutput("reset_busy", 128'(busy), 128'(0));
    checkOutput("reset_done", 128'(mem_rd_done), 128'(0));
    checkOutput("reset_data", mem_rd_data, 128'(0));
    checkOutput("reset_ram_a", 128'(ram_a), 128'(0));

    // Basic fill
    startFill(32'h0000_1234);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1)  checkOutput("basic_a_first", 128'(ram_a), 128'(32'h1230));
      if (c == 16) checkOutput("basic_a_last", 128'(ram_a), 128'(32'h123F));
      if (c == 17) checkOutput("basic_done_early", 128'(mem_rd_done), 128'(0));
      if (c == 18) begin
        checkOutput("basic_done", 128'(mem_rd_done), 128'(1));
        checkOutput("basic_line", mem_rd_data, 128'h3F3E3D3C_3B3A3938_37363534_33323130);
      end
      if (c == 19) checkOutput("basic_done_once", 128'(mem_rd_done), 128'(0));
    end

    // Held request: back-to-back fills every 19 cycles
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0040);
    doneCnt = 0;
    doneAt[0] = -1;
    doneAt[1] = -1;
    for (int c = 1; c <= 37; c++) begin
      @(negedge clk);
      if (mem_rd_done) begin
        if (doneCnt < 2) doneAt[doneCnt] = c;
        doneCnt++;
      end
      if (c == 19) checkOutput("held_gap_rd", 128'(ram_rd), 128'(0));
      if (c == 20) checkOutput("held_second_a", 128'(ram_a), 128'(32'h40));
      if (c == 37) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0000_0040);
    end
    checkOutput("held_done_count", 128'(doneCnt), 128'(2));
    checkOutput("held_done_first", 128'(doneAt[0]), 128'(18));
    checkOutput("held_done_second", 128'(doneAt[1]), 128'(37));
    repeat (3) @(negedge clk);

    // Abort in cycle 8
    startFill(32'h0000_0100);
    for (int c = 1; c <= 8; c++) @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    @(posedge clk);
    #1 applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("abort_busy", 128'(busy), 128'(0));
    checkOutput("abort_rd", 128'(ram_rd), 128'(0));
    checkOutput("abort_a", 128'(ram_a), 128'(0));
    doneCnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (mem_rd_done) doneCnt++;
    end
    checkOutput("abort_no_done", 128'(doneCnt), 128'(0));
    startFill(32'h0000_0200);
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (c == 17) checkOutput("refill_done_early", 128'(mem_rd_done), 128'(0));
      if (c == 18) begin
        checkOutput("refill_done", 128'(mem_rd_done), 128'(1));
        checkOutput("refill_line", mem_rd_data, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
      end
    end
    repeat (3) @(negedge clk);

    // Address at the top of the space
    startFill(32'hFFFF_FFFC);
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (c == 1)  checkOutput("top_a_first", 128'(ram_a), 128'(32'hFFFF_FFF0));
      if (c == 16) checkOutput("top_a_last", 128'(ram_a), 128'(32'hFFFF_FFFF));
      if (c == 18) begin
        checkOutput("top_done", 128'(mem_rd_done), 128'(1));
        checkOutput("top_line", mem_rd_data, 128'hFFFEFDFC_FBFAF9F8_F7F6F5F4_F3F2F1F0);
      end
    end
    repeat (3) @(negedge clk);

    // Reset in cycle 10 of a fill
    startFill(32'h0000_0300);
    for (int c = 1; c <= 10; c++) @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #1 applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("rst_data", mem_rd_data, 128'(0));
    checkOutput("rst_busy", 128'(busy), 128'(0));
    checkOutput("rst_rd", 128'(ram_rd), 128'(0));
    checkOutput("rst_a", 128'(ram_a), 128'(0));
    doneCnt = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (mem_rd_done) doneCnt++;
    end
    checkOutput("rst_no_done", 128'(doneCnt), 128'(0));

    // clr and request in the same IDLE cycle
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0500);
    @(posedge clk);
    #1 applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0500);
    @(negedge clk);
    checkOutput("collide_busy", 128'(busy), 128'(0));
    @(posedge clk);
    #1 applyStimulus(1'b0, 1'b0, 1'b0, 32'h0000_0500);
    @(negedge clk);
    checkOutput("collide_next_busy", 128'(busy), 128'(1));
    checkOutput("collide_next_a", 128'(ram_a), 128'(32'h500));
    repeat (22) @(negedge clk);

    // Randomized traffic against the model
    salt = 8'($urandom_range(1, 255));
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] a;
      @(negedge clk);
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a[31:8] = 24'hFFFFFF;
      applyStimulus($urandom_range(0, 499) == 0, $urandom_range(0, 63) == 0,
                    $urandom_range(0, 2) == 0, a);
    end
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (25) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule

// File: doc/icache_line_fetcher.md
# icache_line_fetcher

Memory-side responder for the instruction-cache line-fill port. It accepts a line-read request from the icache, fetches the 16 bytes of the line from the byte-wide main RAM, and assembles them little-endian into one 128-bit line. It then returns the line with a one-cycle done pulse. It sits between the icache miss path and the RAM/memory arbiter and owns no cache state.

## Interface

Parameters:
- `LINE_BYTES`, default 16: bytes per line; the line is `8*LINE_BYTES` bits wide and must be a power of two.
- `ADDR_W`, default 32: address width.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `clr`  in  1  synchronous abort (pipeline flush); it drops any fill in progress.
- `mem_rd_ena`  in  1  line-read request from the icache.
- `mem_rd_addr`  in  ADDR_W  request address; only bits [ADDR_W-1:4] are used.
- `mem_rd_done`  out  1  one-cycle pulse: `mem_rd_data` is valid.
- `mem_rd_data`  out  8*LINE_BYTES  assembled line.
- `busy`  out  1  high while a fill is in progress.
- `ram_rd`  out  1  RAM read strobe.
- `ram_a`  out  ADDR_W  RAM byte address.
- `ram_din`  in  8  RAM read data; it is valid one cycle after `ram_a`/`ram_rd`.
- `ram_wr`  out  1  tied to 0 (read-only port).

## Operation

- **States:** IDLE, FETCH, DONE.
- **Reset:** `rst` gives state IDLE. All outputs are registered with these reset values:
  - `mem_rd_done`=0, `mem_rd_data`=0, `busy`=0, `ram_rd`=0, `ram_a`=0, `ram_wr`=0.
  - Issue and receive counters are cleared.
- **IDLE:**
  - If `mem_rd_ena`=1 and `clr`=0 at the edge, latch base = {`mem_rd_addr`[ADDR_W-1:4], 4'b0} and move to FETCH.
  - Set `busy`=1, `ram_rd`=1, `ram_a`=base.
- **FETCH issue side:**
  - Issue counter `i` runs 0..15. `ram_a` = base + `i`, computed with a 4-bit offset OR into the base, so there is never a carry into bit 4.
  - After `i`=15, `ram_rd` drops to 0.
- **FETCH receive side:**
  - Receive counter `k` runs 0..15.
  - Starting one edge after the first issue, each edge writes `ram_din` into `mem_rd_data`[8k+7:8k].
- **FETCH exit:** after capturing byte 15, move to DONE with `mem_rd_done`=1.
- **DONE:** lasts one cycle.
  - `mem_rd_done`=1 and `mem_rd_data` holds the line.
  - Next edge: return to IDLE with `mem_rd_done`=0 and `busy`=0.
  - `mem_rd_data` holds its value until the next fill overwrites it.
- **Requests while busy:** `mem_rd_ena` in FETCH or DONE is ignored and never queued. The icache re-asserts its request every cycle while it misses, so duplicates are expected and must not start a second fill.
- **`clr` in FETCH:** at the edge where `clr`=1, go to IDLE. Set `ram_rd`=0, `busy`=0, `ram_a`=0, and clear the counters. No `mem_rd_done` follows, and any byte in flight is discarded.
- **`clr` with a request in IDLE:** `clr` wins and the request is not accepted.
- **`clr` in DONE:** it has no effect, because the pulse is already on the port.
- **`rst` during a fill:** same as `clr`, and it also clears `mem_rd_data`.

## Timing

- Cycle 0 is the cycle in which `mem_rd_ena`=1 is sampled in IDLE.
- Cycles 1..16: `ram_a` = base+0 .. base+15 with `ram_rd`=1.
- Cycles 2..17: `ram_din` carries byte 0 .. byte 15, and each is captured at the end of its cycle.
- Cycle 18: `mem_rd_done`=1 with the full line.
  - Request-to-done latency is exactly 18 cycles.
  - A fill occupies 19 cycles including the DONE cycle.
- Cycle 19: IDLE. A new request sampled in cycle 19 starts the next fill, so back-to-back fills repeat every 19 cycles.
- `mem_rd_done` is never high for two consecutive cycles.
- `busy` is high in cycles 1..18.

## Test plan

- **Basic fill:**
  - Stimulus: reset, then `mem_rd_addr`=0x00001234 with `mem_rd_ena`=1 for one cycle. The RAM model returns byte = addr[7:0].
  - Required: `ram_a` steps 0x1230..0x123F in cycles 1..16, `mem_rd_done` pulses in cycle 18 only, and `mem_rd_data`=0x3F3E3D3C_3B3A3938_37363534_33323130.
- **Held request:**
  - Stimulus: `mem_rd_ena` held high continuously with addr 0x00000040.
  - Required: fills start in cycles 0 and 19, done pulses in cycles 18 and 37, and there is no overlap in the `ram_a` sequences.
- **Abort:**
  - Stimulus: start a fill at 0x100, assert `clr` in cycle 8.
  - Required: cycle 9 has `busy`=0, `ram_rd`=0, `ram_a`=0; no `mem_rd_done` for the following 30 cycles. A new request at 0x200 then completes normally with 18-cycle latency.
- **Address top:**
  - Stimulus: request 0xFFFFFFFC.
  - Required: `ram_a` steps 0xFFFFFFF0..0xFFFFFFFF with no wrap to 0x0; done arrives in cycle 18.
- **Reset mid-fill:**
  - Stimulus: `rst` in cycle 10 of a fill.
  - Required: next cycle all outputs are at reset values, including `mem_rd_data`=0, and no done pulse follows.
- **clr/request collision:**
  - Stimulus: in IDLE, `clr`=1 and `mem_rd_ena`=1 in the same cycle.
  - Required: no fill starts (`busy` stays 0). The request sampled the next cycle, with `clr`=0, is accepted.
